// File: rtl/reg_file_2r2w_param.sv
// Parametrised 2-read/2-write register file with registered, valid-qualified reads,
// bulk clear and write-collision counting. Define REG_FILE_BYPASS_EN for write-through reads.
module reg_file_2r2w_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_in,
    input  logic              a_ren_in,
    input  logic [ADDR_W-1:0] a_raddr_in,
    input  logic              b_ren_in,
    input  logic [ADDR_W-1:0] b_raddr_in,
    input  logic              c_wen_in,
    input  logic [ADDR_W-1:0] c_waddr_in,
    input  logic [DATA_W-1:0] c_in,
    input  logic              d_wen_in,
    input  logic [ADDR_W-1:0] d_waddr_in,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    output logic              wr_collision_out,
    output logic [CNT_W-1:0]  collision_cnt_out
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] a_out_q, a_out_d;
    logic [DATA_W-1:0] b_out_q, b_out_d;
    logic              a_valid_q, b_valid_q;
    logic              coll_q, coll_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_src, b_src;

    // D is applied after C so it wins on a shared address; clear overrides both.
    always_comb begin
        mem_d = mem_q;
        if (clear_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else begin
            if (c_wen_in) mem_d[c_waddr_in] = c_in;
            if (d_wen_in) mem_d[d_waddr_in] = d_in;
        end
    end

    always_comb begin
        coll_d = c_wen_in && d_wen_in && (c_waddr_in == d_waddr_in);
        cnt_d  = cnt_q;
        if (coll_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign a_src = mem_d[a_raddr_in];
    assign b_src = mem_d[b_raddr_in];
`else
    assign a_src = mem_q[a_raddr_in];
    assign b_src = mem_q[b_raddr_in];
`endif

    assign a_out_d = a_ren_in ? a_src : a_out_q;
    assign b_out_d = b_ren_in ? b_src : b_out_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            a_out_q   <= '0;
            b_out_q   <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            coll_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mem_q     <= mem_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
            a_valid_q <= a_ren_in;
            b_valid_q <= b_ren_in;
            coll_q    <= coll_d;
            cnt_q     <= cnt_d;
        end
    end

    assign a_out             = a_out_q;
    assign a_valid_out       = a_valid_q;
    assign b_out             = b_out_q;
    assign b_valid_out       = b_valid_q;
    assign wr_collision_out  = coll_q;
    assign collision_cnt_out = cnt_q;

endmodule

// File: tb/tb_reg_file_2r2w_param.sv
// Bench for reg_file_2r2w_param: table-driven vectors through a scoreboard queue,
// hand sequences for clear, saturation and reset, plus a 32-bit/32-entry instance.
module tb_reg_file_2r2w_param;

    typedef struct {
        logic        clr;
        logic        ar;
        logic [2:0]  aa;
        logic        br;
        logic [2:0]  ba;
        logic        cw;
        logic [2:0]  ca;
        logic [15:0] cd;
        logic        dw;
        logic [2:0]  da;
        logic [15:0] dd;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ec;
    } vec_t;

    typedef struct {
        logic        av;
        logic [15:0] ad;
        logic        bv;
        logic [15:0] bd;
        logic        coll;
        logic [7:0]  cnt;
    } exp_t;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [15:0] BY_BEEF = 16'hBEEF;
    localparam logic [15:0] BY_7777 = 16'h7777;
    localparam logic [15:0] BY_CLR  = 16'h0000;
    localparam logic [31:0] BY_W    = 32'h0;
`else
    localparam logic [15:0] BY_BEEF = 16'h0000;
    localparam logic [15:0] BY_7777 = 16'h0000;
    localparam logic [15:0] BY_CLR  = 16'h1003;
    localparam logic [31:0] BY_W    = 32'h2;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic clr, a_ren, b_ren, c_wen, d_wen;
    logic [2:0]  a_addr, b_addr, c_addr, d_addr;
    logic [15:0] c_d, d_d, a_out, b_out;
    logic        a_valid, b_valid, coll;
    logic [7:0]  cnt;

    logic w_clr, w_a_ren, w_b_ren, w_c_wen, w_d_wen;
    logic [4:0]  w_a_addr, w_b_addr, w_c_addr, w_d_addr;
    logic [31:0] w_c_d, w_d_d, w_a_out, w_b_out;
    logic        w_a_valid, w_b_valid, w_coll;
    logic [7:0]  w_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    vec_t tbl[11];
    logic [7:0] cnt_m;

    always #5 clock = ~clock;

    reg_file_2r2w_param dut (
        .clock(clock), .reset_n(reset_n), .clear_in(clr),
        .a_ren_in(a_ren), .a_raddr_in(a_addr), .b_ren_in(b_ren), .b_raddr_in(b_addr),
        .c_wen_in(c_wen), .c_waddr_in(c_addr), .c_in(c_d),
        .d_wen_in(d_wen), .d_waddr_in(d_addr), .d_in(d_d),
        .a_out(a_out), .a_valid_out(a_valid), .b_out(b_out), .b_valid_out(b_valid),
        .wr_collision_out(coll), .collision_cnt_out(cnt)
    );

    reg_file_2r2w_param #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut_w (
        .clock(clock), .reset_n(reset_n), .clear_in(w_clr),
        .a_ren_in(w_a_ren), .a_raddr_in(w_a_addr), .b_ren_in(w_b_ren), .b_raddr_in(w_b_addr),
        .c_wen_in(w_c_wen), .c_waddr_in(w_c_addr), .c_in(w_c_d),
        .d_wen_in(w_d_wen), .d_waddr_in(w_d_addr), .d_in(w_d_d),
        .a_out(w_a_out), .a_valid_out(w_a_valid), .b_out(w_b_out), .b_valid_out(w_b_valid),
        .wr_collision_out(w_coll), .collision_cnt_out(w_cnt)
    );

    function automatic vec_t mkv(input logic clr_v, input logic ar, input logic [2:0] aa,
                                 input logic br, input logic [2:0] ba,
                                 input logic cw, input logic [2:0] ca, input logic [15:0] cd,
                                 input logic dw, input logic [2:0] da, input logic [15:0] dd,
                                 input logic [15:0] ea, input logic [15:0] eb, input logic ec);
        vec_t v;
        v.clr = clr_v; v.ar = ar; v.aa = aa; v.br = br; v.ba = ba;
        v.cw = cw; v.ca = ca; v.cd = cd; v.dw = dw; v.da = da; v.dd = dd;
        v.ea = ea; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    function automatic exp_t mke(input logic av, input logic [15:0] ad, input logic bv,
                                 input logic [15:0] bd, input logic cl, input logic [7:0] cn);
        exp_t e;
        e.av = av; e.ad = ad; e.bv = bv; e.bd = bd; e.coll = cl; e.cnt = cn;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        clr = v.clr; a_ren = v.ar; a_addr = v.aa; b_ren = v.br; b_addr = v.ba;
        c_wen = v.cw; c_addr = v.ca; c_d = v.cd; d_wen = v.dw; d_addr = v.da; d_d = v.dd;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("a_valid", 32'(a_valid), 32'(e.av));
            chk("a_out",   32'(a_out),   32'(e.ad));
            chk("b_valid", 32'(b_valid), 32'(e.bv));
            chk("b_out",   32'(b_out),   32'(e.bd));
            chk("coll",    32'(coll),    32'(e.coll));
            chk("cnt",     32'(cnt),     32'(e.cnt));
        end
    endtask

    task automatic apply(input vec_t v, input exp_t e);
        drive(v);
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_out"},   32'(a_out),   32'd0);
        chk({tag, "_a_valid"}, 32'(a_valid), 32'd0);
        chk({tag, "_b_out"},   32'(b_out),   32'd0);
        chk({tag, "_b_valid"}, 32'(b_valid), 32'd0);
        chk({tag, "_coll"},    32'(coll),    32'd0);
        chk({tag, "_cnt"},     32'(cnt),     32'd0);
    endtask

    task automatic w_cycle();
        @(posedge clock);
        #1;
        w_clr = 0; w_a_ren = 0; w_b_ren = 0; w_c_wen = 0; w_d_wen = 0;
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        logic [15:0] ha, hb;
        idle = mkv(0,0,0,0,0,0,0,16'h0,0,0,16'h0,16'h0,16'h0,0);
        drive(idle);
        w_clr = 0; w_a_ren = 0; w_a_addr = 0; w_b_ren = 0; w_b_addr = 0;
        w_c_wen = 0; w_c_addr = 0; w_c_d = 0; w_d_wen = 0; w_d_addr = 0; w_d_d = 0;

        //          clr ar aa br ba cw ca cd        dw da dd        ea        eb        ec
        tbl[0]  = mkv(0, 0,0, 0,0, 1,3,16'hA5A5, 0,0,16'h0000, 16'h0000, 16'h0000, 0);
        tbl[1]  = mkv(0, 1,3, 0,0, 0,0,16'h0000, 0,0,16'h0000, 16'hA5A5, 16'h0000, 0);
        tbl[2]  = mkv(0, 0,0, 0,0, 1,5,16'h1111, 1,5,16'h2222, 16'hA5A5, 16'h0000, 1);
        tbl[3]  = mkv(0, 1,5, 1,5, 0,0,16'h0000, 0,0,16'h0000, 16'h2222, 16'h2222, 0);
        tbl[4]  = mkv(0, 0,0, 0,0, 1,1,16'h0001, 1,6,16'h0006, 16'h2222, 16'h2222, 0);
        tbl[5]  = mkv(0, 1,1, 1,6, 0,0,16'h0000, 0,0,16'h0000, 16'h0001, 16'h0006, 0);
        tbl[6]  = mkv(0, 1,2, 0,0, 1,2,16'hBEEF, 0,0,16'h0000, BY_BEEF,  16'h0006, 0);
        tbl[7]  = mkv(0, 1,2, 1,2, 0,0,16'h0000, 0,0,16'h0000, 16'hBEEF, 16'hBEEF, 0);
        tbl[8]  = mkv(0, 0,0, 1,7, 0,0,16'h0000, 1,7,16'h7777, 16'hBEEF, BY_7777,  0);
        tbl[9]  = mkv(0, 0,0, 1,7, 0,0,16'h0000, 0,0,16'h0000, 16'hBEEF, 16'h7777, 0);
        tbl[10] = mkv(0, 1,0, 0,0, 0,0,16'h0000, 0,0,16'h0000, 16'h0000, 16'h7777, 0);

        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        cnt_m = 8'd0;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].ec && cnt_m != 8'hFF) cnt_m++;
            apply(tbl[i], mke(tbl[i].ar, tbl[i].ea, tbl[i].br, tbl[i].eb, tbl[i].ec, cnt_m));
        end
        ha = 16'h0000;
        hb = 16'h7777;

        // fill, then clear while writing addr0 and reading addr3 in the same cycle
        for (int i = 0; i < 8; i++) begin
            apply(mkv(0,0,0,0,0,1,3'(i),16'h1000 + 16'(i),0,0,16'h0,0,0,0),
                  mke(0, ha, 0, hb, 0, cnt_m));
        end
        apply(mkv(1,1,3,0,0,1,0,16'hFFFF,0,0,16'h0,0,0,0), mke(1, BY_CLR, 0, hb, 0, cnt_m));
        for (int i = 0; i < 8; i++) begin
            apply(mkv(0,1,3'(i),1,3'(7-i),0,0,16'h0,0,0,16'h0,0,0,0),
                  mke(1, 16'h0, 1, 16'h0, 0, cnt_m));
        end
        cnt_m++;
        apply(mkv(1,0,0,0,0,1,4,16'hAAAA,1,4,16'hBBBB,0,0,0), mke(0, 16'h0, 0, 16'h0, 1, cnt_m));
        apply(mkv(0,1,4,0,0,0,0,16'h0,0,0,16'h0,0,0,0), mke(1, 16'h0, 0, 16'h0, 0, cnt_m));

        for (int k = 0; k < 300; k++) begin
            if (cnt_m != 8'hFF) cnt_m++;
            apply(mkv(0,0,0,0,0,1,5,16'h1111,1,5,16'h2222,0,0,0), mke(0, 16'h0, 0, 16'h0, 1, cnt_m));
        end
        chk("cnt_saturated", 32'(cnt), 32'd255);
        apply(mkv(0,1,5,0,0,0,0,16'h0,0,0,16'h0,0,0,0), mke(1, 16'h2222, 0, 16'h0, 0, 8'hFF));

        // asynchronous reset in the middle of a write/read burst
        drive(mkv(0,1,5,1,5,1,1,16'h1234,1,2,16'h5678,0,0,0));
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clock);
        #1;
        chk_zero("rst_hold");
        reset_n = 1'b1;
        drive(idle);
        apply(mkv(0,1,1,1,2,0,0,16'h0,0,0,16'h0,0,0,0), mke(1, 16'h0, 1, 16'h0, 0, 8'h0));
        apply(mkv(0,1,5,1,3,0,0,16'h0,0,0,16'h0,0,0,0), mke(1, 16'h0, 1, 16'h0, 0, 8'h0));
        drive(idle);

        // wide configuration
        w_c_wen = 1; w_c_addr = 5'd31; w_c_d = 32'hDEADBEEF;
        w_d_wen = 1; w_d_addr = 5'd17; w_d_d = 32'hCAFEF00D;
        w_cycle();
        chk("w_no_coll", 32'(w_coll), 32'd0);
        w_a_ren = 1; w_a_addr = 5'd31; w_b_ren = 1; w_b_addr = 5'd17;
        w_cycle();
        chk("w_a_out", w_a_out, 32'hDEADBEEF);
        chk("w_b_out", w_b_out, 32'hCAFEF00D);
        chk("w_a_valid", 32'(w_a_valid), 32'd1);
        w_c_wen = 1; w_c_addr = 5'd0; w_c_d = 32'h1;
        w_d_wen = 1; w_d_addr = 5'd0; w_d_d = 32'h2;
        w_cycle();
        chk("w_coll", 32'(w_coll), 32'd1);
        chk("w_cnt", 32'(w_cnt), 32'd1);
        w_clr = 1; w_a_ren = 1; w_a_addr = 5'd0;
        w_cycle();
        chk("w_clr_read", w_a_out, BY_W);
        chk("w_cnt_kept", 32'(w_cnt), 32'd1);
        w_a_ren = 1; w_a_addr = 5'd31; w_b_ren = 1; w_b_addr = 5'd0;
        w_cycle();
        chk("w_a_cleared", w_a_out, 32'h0);
        chk("w_b_cleared", w_b_out, 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
